// File: rtl/axis_beam_splitter.sv
// axis_beam_splitter
// Fans one AXI-Stream of complex baseband samples out to four antenna
// channels (00, 01, 20, 21). Every channel multiplies each lane by its own
// complex weight, rounds half-up, and saturates to the sample width.
// Weight updates take effect only at frame boundaries, so a frame is never
// split across two weight sets.
//
// Ports
//   clock, resetn   rising-edge clock, synchronous active-low reset
//   wt_load, wt_in  capture a new pending weight set; ch k at [k*2W+:2W] = {imag,real}
//   s_axis_*        input stream; lane n: I=[n*2S+:S], Q=[n*2S+S+:S]
//   m_axis_*        four output streams; ch k data at [k*DATA_WIDTH+:DATA_WIDTH]
//   frame_count     number of accepted input tlast beats (wraps)
//   sat_flag        sticky: some output component has been clipped since reset
module axis_beam_splitter #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      wt_load,
  input  logic [8*WEIGHT_WIDTH-1:0] wt_in,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [4*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [3:0]                m_axis_tvalid,
  input  logic [3:0]                m_axis_tready,
  output logic [3:0]                m_axis_tlast,
  output logic [CNT_WIDTH-1:0]      frame_count,
  output logic                      sat_flag
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned LW    = 2 * SAMPLE_WIDTH;          // one complex lane
  localparam int unsigned NS    = DATA_WIDTH / LW;           // lanes per beat
  localparam int unsigned CWW   = 2 * WEIGHT_WIDTH;          // one complex weight
  localparam int unsigned WVW   = NCH * CWW;                 // whole weight vector
  localparam int unsigned PW    = SAMPLE_WIDTH + WEIGHT_WIDTH; // product width
  localparam int unsigned AW    = PW + 1;                    // accumulator width
  localparam int unsigned SHIFT = WEIGHT_WIDTH - 1;          // Q1.(W-1) scaling

  localparam logic signed [AW-1:0] RND_BIAS = AW'(1) << (WEIGHT_WIDTH - 2);
  localparam logic signed [AW-1:0] SAT_MAX  =
    {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  =
    {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  // Unity gain on every channel: imag = 0, real = 0.99...
  localparam logic [WVW-1:0] WT_RESET =
    {NCH{{WEIGHT_WIDTH{1'b0}}, 1'b0, {(WEIGHT_WIDTH-1){1'b1}}}};

  logic [WVW-1:0]            wt_active;
  logic [WVW-1:0]            wt_pending;
  logic [WVW-1:0]            wt_pending_next;
  logic                      in_frame;
  logic                      accept;
  logic [NCH*DATA_WIDTH-1:0] beat_data;
  logic                      beat_clip;

  // Round half up, then clip; result is {clipped, value}.
  function automatic logic [SAMPLE_WIDTH:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] sh;
    sum = acc + RND_BIAS;
    sh  = sum >>> SHIFT;
    if (sh > SAT_MAX) begin
      round_sat = {1'b1, SAT_MAX[SAMPLE_WIDTH-1:0]};
    end else if (sh < SAT_MIN) begin
      round_sat = {1'b1, SAT_MIN[SAMPLE_WIDTH-1:0]};
    end else begin
      round_sat = {1'b0, sh[SAMPLE_WIDTH-1:0]};
    end
  endfunction

  // Input is taken only when every held output beat leaves this cycle.
  assign s_axis_tready   = ~resetn | (&(~m_axis_tvalid | m_axis_tready));
  assign accept          = s_axis_tvalid & s_axis_tready;
  assign wt_pending_next = wt_load ? wt_in : wt_pending;

  // Complex multiply of every lane by every channel's active weight.
  always_comb begin
    logic signed [WEIGHT_WIDTH-1:0] w_r;
    logic signed [WEIGHT_WIDTH-1:0] w_i;
    logic signed [SAMPLE_WIDTH-1:0] s_i;
    logic signed [SAMPLE_WIDTH-1:0] s_q;
    logic signed [AW-1:0]           acc_i;
    logic signed [AW-1:0]           acc_q;
    logic [SAMPLE_WIDTH:0]          res_i;
    logic [SAMPLE_WIDTH:0]          res_q;
    beat_data = '0;
    beat_clip = 1'b0;
    w_r       = '0;
    w_i       = '0;
    s_i       = '0;
    s_q       = '0;
    acc_i     = '0;
    acc_q     = '0;
    res_i     = '0;
    res_q     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_r = wt_active[k*CWW +: WEIGHT_WIDTH];
      w_i = wt_active[k*CWW + WEIGHT_WIDTH +: WEIGHT_WIDTH];
      for (int unsigned n = 0; n < NS; n++) begin
        s_i   = s_axis_tdata[n*LW +: SAMPLE_WIDTH];
        s_q   = s_axis_tdata[n*LW + SAMPLE_WIDTH +: SAMPLE_WIDTH];
        acc_i = AW'(PW'(s_i) * PW'(w_r)) - AW'(PW'(s_q) * PW'(w_i));
        acc_q = AW'(PW'(s_i) * PW'(w_i)) + AW'(PW'(s_q) * PW'(w_r));
        res_i = round_sat(acc_i);
        res_q = round_sat(acc_q);
        beat_data[k*DATA_WIDTH + n*LW +: SAMPLE_WIDTH]                = res_i[SAMPLE_WIDTH-1:0];
        beat_data[k*DATA_WIDTH + n*LW + SAMPLE_WIDTH +: SAMPLE_WIDTH] = res_q[SAMPLE_WIDTH-1:0];
        beat_clip = beat_clip | res_i[SAMPLE_WIDTH] | res_q[SAMPLE_WIDTH];
      end
    end
  end

  // Output banks, frame tracking, weight handover and status.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= '0;
      m_axis_tlast  <= '0;
      frame_count   <= '0;
      sat_flag      <= 1'b0;
      in_frame      <= 1'b0;
      wt_active     <= WT_RESET;
      wt_pending    <= WT_RESET;
    end else begin
      wt_pending <= wt_pending_next;

      // The tlast beat itself was weighted with the old set above.
      if ((accept && s_axis_tlast) || (!in_frame && !accept)) begin
        wt_active <= wt_pending_next;
      end

      if (accept) begin
        in_frame      <= ~s_axis_tlast;
        m_axis_tdata  <= beat_data;
        m_axis_tvalid <= '1;
        m_axis_tlast  <= {NCH{s_axis_tlast}};
      end else begin
        m_axis_tvalid <= m_axis_tvalid & ~m_axis_tready;
      end

      if (accept && s_axis_tlast) begin
        frame_count <= frame_count + CNT_WIDTH'(1);
      end

      if (accept && beat_clip) begin
        sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_beam_splitter.sv
// Bench for axis_beam_splitter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_axis_beam_splitter;

  localparam int DW  = 128;
  localparam int CW  = 16;
  localparam int NCH = 4;
  localparam int NS  = 4;
  localparam logic [63:0] WRST = {4{16'h007F}};

  logic              clock         = 1'b0;
  logic              resetn        = 1'b0;
  logic              wt_load       = 1'b0;
  logic [63:0]       wt_in         = '0;
  logic [DW-1:0]     s_axis_tdata  = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast  = 1'b0;
  logic [4*DW-1:0]   m_axis_tdata;
  logic [3:0]        m_axis_tvalid;
  logic [3:0]        m_axis_tready = 4'hF;
  logic [3:0]        m_axis_tlast;
  logic [CW-1:0]     frame_count;
  logic              sat_flag;

  axis_beam_splitter dut (
    .clock         (clock),
    .resetn        (resetn),
    .wt_load       (wt_load),
    .wt_in         (wt_in),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_count   (frame_count),
    .sat_flag      (sat_flag)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] exp_d [NCH];
  logic [3:0]    exp_v    = '0;
  logic [3:0]    exp_l    = '0;
  logic [63:0]   m_act    = WRST;
  logic [63:0]   m_pend   = WRST;
  logic          m_inf    = 1'b0;
  logic [CW-1:0] m_fc     = '0;
  logic          m_sat    = 1'b0;
  logic          last_acc = 1'b0;
  logic          exp_rdy;
  logic          m_accept;
  logic          any_clip;
  logic          one_clip;
  logic [63:0]   pend_nx;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One channel's output beat: complex product, round half up, clip.
  function automatic logic [DW-1:0] mdl_chan(input logic [DW-1:0] d, input logic [63:0] w,
                                             input int k, output logic clip);
    int wr, wi, si, sq, ri, rq, ci, cq;
    logic [DW-1:0] r;
    r    = '0;
    clip = 1'b0;
    wr   = int'($signed(w[k*16 +: 8]));
    wi   = int'($signed(w[k*16+8 +: 8]));
    for (int n = 0; n < NS; n++) begin
      si = int'($signed(d[n*32 +: 16]));
      sq = int'($signed(d[n*32+16 +: 16]));
      ri = (si*wr - sq*wi + 64) >>> 7;
      rq = (si*wi + sq*wr + 64) >>> 7;
      ci = clamp16(ri);
      cq = clamp16(rq);
      if (ci != ri || cq != rq) clip = 1'b1;
      r[n*32 +: 16]    = 16'(ci);
      r[n*32+16 +: 16] = 16'(cq);
    end
    return r;
  endfunction

  // Check DUT against model, then advance the model to the next rising edge.
  always @(negedge clock) begin
    exp_rdy = 1'b1;
    for (int k = 0; k < NCH; k++) if (exp_v[k] && !m_axis_tready[k]) exp_rdy = 1'b0;
    if (!resetn) exp_rdy = 1'b1;

    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("tvalid_ch%0d", k), DW'(m_axis_tvalid[k]), DW'(exp_v[k]));
      if (exp_v[k]) begin
        chk($sformatf("tdata_ch%0d", k), m_axis_tdata[k*DW +: DW], exp_d[k]);
        chk($sformatf("tlast_ch%0d", k), DW'(m_axis_tlast[k]), DW'(exp_l[k]));
      end
    end
    chk("s_tready", DW'(s_axis_tready), DW'(exp_rdy));
    chk("frame_count", DW'(frame_count), DW'(m_fc));
    chk("sat_flag", DW'(sat_flag), DW'(m_sat));

    if (!resetn) begin
      exp_v    = '0;
      m_act    = WRST;
      m_pend   = WRST;
      m_inf    = 1'b0;
      m_fc     = '0;
      m_sat    = 1'b0;
      last_acc = 1'b0;
    end else begin
      m_accept = s_axis_tvalid && exp_rdy;
      pend_nx  = wt_load ? wt_in : m_pend;
      for (int k = 0; k < NCH; k++) if (m_axis_tready[k]) exp_v[k] = 1'b0;
      if (m_accept) begin
        any_clip = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          exp_d[k] = mdl_chan(s_axis_tdata, m_act, k, one_clip);
          any_clip = any_clip | one_clip;
        end
        exp_v = '1;
        exp_l = {4{s_axis_tlast}};
        if (any_clip) m_sat = 1'b1;
        if (s_axis_tlast) m_fc = m_fc + 16'd1;
      end
      if ((m_accept && s_axis_tlast) || (!m_inf && !m_accept)) m_act = pend_nx;
      m_pend = pend_nx;
      if (m_accept) m_inf = !s_axis_tlast;
      last_acc = m_accept;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_beat(input int i, input int q);
    logic [DW-1:0] d;
    for (int n = 0; n < NS; n++) begin
      d[n*32 +: 16]    = 16'(i);
      d[n*32+16 +: 16] = 16'(q);
    end
    return d;
  endfunction

  function automatic logic [15:0] lane(input int k, input int n, input int q);
    return m_axis_tdata[k*DW + n*32 + q*16 +: 16];
  endfunction

  function automatic logic [15:0] rnd_comp();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 16'h7FFF;
    if (r == 1) return 16'h8000;
    return 16'($urandom);
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int n = 0; n < 2*NS; n++) d[n*16 +: 16] = rnd_comp();
    return d;
  endfunction

  task automatic send(input int i, input int q, input logic last);
    s_axis_tdata  = mk_beat(i, q);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  logic [63:0] w;
  logic        have;

  initial begin
    // Reset state
    resetn        = 1'b0;
    m_axis_tready = 4'hF;
    repeat (3) step();
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(4'h0));
    chk("rst_tlast", DW'(m_axis_tlast), DW'(4'h0));
    chk("rst_fc", DW'(frame_count), '0);
    chk("rst_sat", DW'(sat_flag), '0);
    chk("rst_tready", DW'(s_axis_tready), DW'(1));
    for (int k = 0; k < NCH; k++) chk("rst_tdata", m_axis_tdata[k*DW +: DW], '0);
    resetn = 1'b1;
    step();

    // Unity-ish weights: 1000 * 127/128 rounds to 992 on every channel
    send(1000, 0, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    chk("t1_tvalid", DW'(m_axis_tvalid), DW'(4'hF));
    for (int k = 0; k < NCH; k++) begin
      chk("t1_I", DW'(lane(k, 0, 0)), DW'(16'd992));
      chk("t1_Q", DW'(lane(k, 3, 1)), DW'(16'd0));
    end
    step();

    // Channel 1 weight = j: rotates I into Q
    w = WRST;
    w[16 +: 16] = 16'h7F00;
    wt_in   = w;
    wt_load = 1'b1;
    step();
    wt_load = 1'b0;
    step();
    send(1000, 0, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    chk("t2_ch1_I", DW'(lane(1, 0, 0)), DW'(16'd0));
    chk("t2_ch1_Q", DW'(lane(1, 2, 1)), DW'(16'd992));
    chk("t2_ch0_I", DW'(lane(0, 1, 0)), DW'(16'd992));
    chk("t2_ch3_Q", DW'(lane(3, 1, 1)), DW'(16'd0));
    step();

    // Channel 2 weight = -1 on full-scale input: Q clips
    w = WRST;
    w[32 +: 16] = 16'h0080;
    wt_in   = w;
    wt_load = 1'b1;
    step();
    wt_load = 1'b0;
    step();
    chk("t3_sat_before", DW'(sat_flag), DW'(0));
    send(32767, -32768, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    chk("t3_ch2_I", DW'(lane(2, 0, 0)), DW'(16'h8001));
    chk("t3_ch2_Q", DW'(lane(2, 0, 1)), DW'(16'h7FFF));
    chk("t3_sat", DW'(sat_flag), DW'(1));
    repeat (3) step();
    chk("t3_sat_sticky", DW'(sat_flag), DW'(1));

    // Backpressure on channel 2 only
    m_axis_tready = 4'b1011;
    send(100, 200, 1'b0);
    step();
    send(-300, 400, 1'b1);
    chk("t4_tvalid0", DW'(m_axis_tvalid), DW'(4'hF));
    chk("t4_tready0", DW'(s_axis_tready), DW'(0));
    repeat (4) begin
      step();
      chk("t4_tvalid", DW'(m_axis_tvalid), DW'(4'b0100));
      chk("t4_tready", DW'(s_axis_tready), DW'(0));
    end
    m_axis_tready = 4'hF;
    step();
    s_axis_tvalid = 1'b0;
    chk("t4_beat1_valid", DW'(m_axis_tvalid), DW'(4'hF));
    chk("t4_beat1_last", DW'(m_axis_tlast), DW'(4'hF));
    step();

    // Reset while beats are held
    m_axis_tready = 4'h0;
    send(1000, 0, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    step();
    chk("t5_held", DW'(m_axis_tvalid), DW'(4'hF));
    resetn = 1'b0;
    #1;
    chk("t5_tready_rst", DW'(s_axis_tready), DW'(1));
    step();
    chk("t5_tvalid", DW'(m_axis_tvalid), DW'(4'h0));
    chk("t5_fc", DW'(frame_count), '0);
    chk("t5_sat", DW'(sat_flag), '0);
    resetn        = 1'b1;
    m_axis_tready = 4'hF;
    step();

    // Three-beat frame with a weight load mid-frame
    send(1000, 0, 1'b0);
    step();
    chk("t6_b1_ch2_I", DW'(lane(2, 0, 0)), DW'(16'd992));
    send(1000, 0, 1'b0);
    wt_in   = {4{16'h0040}};
    wt_load = 1'b1;
    step();
    wt_load = 1'b0;
    chk("t6_b2_ch0_I", DW'(lane(0, 0, 0)), DW'(16'd992));
    send(1000, 0, 1'b1);
    chk("t6_fc0", DW'(frame_count), DW'(16'd0));
    step();
    chk("t6_b3_ch1_I", DW'(lane(1, 0, 0)), DW'(16'd992));
    chk("t6_fc1", DW'(frame_count), DW'(16'd1));
    send(1000, 0, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    chk("t6_b4_ch0_I", DW'(lane(0, 0, 0)), DW'(16'd500));
    chk("t6_b4_ch3_I", DW'(lane(3, 2, 0)), DW'(16'd500));
    chk("t6_fc2", DW'(frame_count), DW'(16'd2));
    step();

    // Randomized traffic
    have = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (last_acc) have = 1'b0;
      resetn = !(c >= 1500 && c < 1502);
      if (!resetn) have = 1'b0;
      if (resetn && !have && $urandom_range(0, 9) < 7) begin
        s_axis_tdata = rnd_data();
        s_axis_tlast = ($urandom_range(0, 3) == 0);
        have = 1'b1;
      end
      s_axis_tvalid = have;
      wt_load = ($urandom_range(0, 9) == 0);
      wt_in   = {$urandom, $urandom};
      for (int k = 0; k < NCH; k++) m_axis_tready[k] = ($urandom_range(0, 3) != 0);
      step();
    end
    s_axis_tvalid = 1'b0;
    wt_load       = 1'b0;
    m_axis_tready = 4'hF;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
